// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, reset vector, fetch FSM states and fetch entry type
package cpu_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of fetch entries with synchronous clear
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // Storage, pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + {{PW{1'b0}}, i_push} - {{PW{1'b0}}, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch stage: pc, sram0 read issue, prefetch queue toward decode
module inst_fetch_queue #(
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [ADDR_WIDTH-1:0]     inst_addr,
    output logic                      inst_re,
    input  logic [DATA_WIDTH-1:0]     inst_rdata,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    input  logic                      halt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_inst,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int CW = $clog2(DEPTH) + 1;

    cpu_pkg::fetch_state_t r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_pending_pc;

    logic [CW:0]           w_occupancy;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    cpu_pkg::fetch_entry_t w_push_entry;
    cpu_pkg::fetch_entry_t w_head;
    logic [CW-1:0]         w_count;

    // Queued entries plus the one in flight must never exceed the queue size,
    // so a returning response always has a free slot.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_pending};
    assign w_issue     = (r_state == cpu_pkg::FETCH) && !halt && !redirect_valid
                         && (w_occupancy < (CW+1)'(DEPTH));
    assign w_push      = r_pending && !redirect_valid;
    assign w_pop       = out_valid && out_ready;

    assign w_push_entry.pc   = r_pending_pc;
    assign w_push_entry.inst = inst_rdata;

    // Fetch control FSM; redirects do not change the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= cpu_pkg::BOOT;
        end else begin
            case (r_state)
                cpu_pkg::BOOT:  r_state <= halt ? cpu_pkg::HOLD : cpu_pkg::FETCH;
                cpu_pkg::FETCH: if (halt)  r_state <= cpu_pkg::HOLD;
                cpu_pkg::HOLD:  if (!halt) r_state <= cpu_pkg::FETCH;
                default:        r_state <= cpu_pkg::BOOT;
            endcase
        end
    end

    // Program counter and in-flight tracking; a redirect discards the in-flight read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= cpu_pkg::RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
        end else if (redirect_valid) begin
            r_pc      <= redirect_pc;
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pc         <= r_pc + ADDR_WIDTH'(1);
                r_pending_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (redirect_valid),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign inst_addr = r_pc;
    assign inst_re   = w_issue;
    assign out_valid = (w_count != '0);
    assign out_inst  = w_head.inst;
    assign out_pc    = w_head.pc;
    assign count     = w_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] inst_addr;
    logic        inst_re;
    logic [15:0] inst_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .DEPTH      (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inst_addr      (inst_addr),
        .inst_re        (inst_re),
        .inst_rdata     (inst_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // sram0: word k holds 16'h7000+k, one-cycle read latency; garbage when not read
    always @(posedge clk) begin
        if (inst_re) inst_rdata <= 16'h7000 + inst_addr;
        else         inst_rdata <= 16'hDEAD;
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] w;
        w = 16'h7000 + a;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n        = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        out_ready      = ready;
        #1;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        out_ready      = 1'b1;
        tick();
        tick();
        chk("rst_addr",  32'(inst_addr), 32'h0);
        chk("rst_re",    32'(inst_re),   32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst",  32'(out_inst),  32'h0);
        chk("rst_pc",    32'(out_pc),    32'h0);
        chk("rst_count", 32'(count),     32'h0);

        // Streaming with decode always ready
        reset_n = 1'b1;
        chk("boot_re", 32'(inst_re), 32'h0);
        tick();
        chk("a_re0",    32'(inst_re),   32'h1);
        chk("a_addr0",  32'(inst_addr), 32'h0);
        chk("a_valid0", 32'(out_valid), 32'h0);
        tick();
        chk("a_addr1",  32'(inst_addr), 32'h1);
        chk("a_valid1", 32'(out_valid), 32'h0);
        tick();
        chk("a_first_valid", 32'(out_valid), 32'h1);
        chk("a_first_pc",    32'(out_pc),    32'h0);
        chk("a_first_inst",  32'(out_inst),  32'h7000);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("a_stream_valid", 32'(out_valid), 32'h1);
            chk("a_stream_pc",    32'(out_pc),    32'(k));
            chk("a_stream_inst",  32'(out_inst),  32'(word_at(16'(k))));
            chk("a_stream_count", 32'(count),     32'h1);
        end

        // Backpressure: queue fills to DEPTH then issue stops
        do_reset(1'b0);
        tick(); tick(); tick(); tick();
        chk("b_count2", 32'(count),   32'd2);
        chk("b_re2",    32'(inst_re), 32'h1);
        tick();
        chk("b_count3", 32'(count),   32'd3);
        chk("b_re3",    32'(inst_re), 32'h0);
        tick();
        chk("b_full_count", 32'(count),     32'd4);
        chk("b_full_re",    32'(inst_re),   32'h0);
        chk("b_full_addr",  32'(inst_addr), 32'h4);
        chk("b_full_pc",    32'(out_pc),    32'h0);
        tick();
        chk("b_hold_count", 32'(count),    32'd4);
        chk("b_hold_pc",    32'(out_pc),   32'h0);
        chk("b_hold_inst",  32'(out_inst), 32'h7000);
        out_ready = 1'b1;
        #1;
        chk("b_release_re", 32'(inst_re), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("b_drain_valid", 32'(out_valid), 32'h1);
            chk("b_drain_pc",    32'(out_pc),    32'(k));
            chk("b_drain_inst",  32'(out_inst),  32'(word_at(16'(k))));
            if (k == 1) begin
                chk("b_resume_re",   32'(inst_re),   32'h1);
                chk("b_resume_addr", 32'(inst_addr), 32'h4);
            end
        end

        // Redirect while pc 5 is in flight and two entries are queued
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("c_head3", 32'(out_pc), 32'h3);
        out_ready = 1'b0;
        tick();
        chk("c_count2", 32'(count),   32'd2);
        chk("c_re",     32'(inst_re), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        chk("c_redir_re", 32'(inst_re), 32'h0);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        chk("c_clr_count", 32'(count),     32'd0);
        chk("c_clr_valid", 32'(out_valid), 32'h0);
        chk("c_addr40",    32'(inst_addr), 32'h40);
        chk("c_re40",      32'(inst_re),   32'h1);
        tick();
        chk("c_n2_valid", 32'(out_valid), 32'h0);
        tick();
        chk("c_n3_valid", 32'(out_valid), 32'h1);
        chk("c_n3_pc",    32'(out_pc),    32'h40);
        chk("c_n3_inst",  32'(out_inst),  32'h7040);
        tick();
        chk("c_next_pc", 32'(out_pc), 32'h41);

        // Redirect coincident with the pc 3 handshake
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0080;
        #1;
        chk("d_hs_valid", 32'(out_valid), 32'h1);
        chk("d_hs_pc",    32'(out_pc),    32'h3);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("d_clr_valid", 32'(out_valid), 32'h0);
        chk("d_clr_count", 32'(count),     32'd0);
        tick();
        chk("d_n2_valid", 32'(out_valid), 32'h0);
        tick();
        chk("d_n3_valid", 32'(out_valid), 32'h1);
        chk("d_n3_pc",    32'(out_pc),    32'h80);

        // Halt for five cycles: drain, no issue, then resume sequentially
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("e_head2", 32'(out_pc), 32'h2);
        halt = 1'b1;
        #1;
        chk("e_halt_re", 32'(inst_re), 32'h0);
        tick();
        chk("e_h0_re",    32'(inst_re),   32'h0);
        chk("e_h0_valid", 32'(out_valid), 32'h1);
        chk("e_h0_pc",    32'(out_pc),    32'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("e_h_re",    32'(inst_re),   32'h0);
            chk("e_h_count", 32'(count),     32'd0);
            chk("e_h_valid", 32'(out_valid), 32'h0);
        end
        halt = 1'b0;
        #1;
        chk("e_hold_re", 32'(inst_re), 32'h0);
        tick();
        chk("e_resume_re",   32'(inst_re),   32'h1);
        chk("e_resume_addr", 32'(inst_addr), 32'h4);
        tick();
        tick();
        chk("e_resume_valid", 32'(out_valid), 32'h1);
        chk("e_resume_pc",    32'(out_pc),    32'h4);

        // Redirect near the top of the address space: pc wraps to zero
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("f_addr_fffe", 32'(inst_addr), 32'hFFFE);
        tick();
        chk("f_addr_ffff", 32'(inst_addr), 32'hFFFF);
        tick();
        chk("f_addr_0000", 32'(inst_addr), 32'h0000);
        begin
            logic [15:0] exp_pc;
            exp_pc = 16'hFFFE;
            for (int i = 0; i < 4; i++) begin
                if (i != 0) tick();
                chk("f_wrap_valid", 32'(out_valid), 32'h1);
                chk("f_wrap_pc",    32'(out_pc),    32'(exp_pc));
                chk("f_wrap_inst",  32'(out_inst),  32'(word_at(exp_pc)));
                exp_pc = exp_pc + 16'h1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Front-end instruction fetch stage of the 16-bit pipelined CPU. It owns the program counter, drives the instruction SRAM (sram0) address port, and buffers returned instruction words with their addresses in a small prefetch queue. The queue feeds the decode stage over a valid/ready handshake. It accepts branch redirects (BUN/BSA/ISZ-skip resolved in execute) and discards stale in-flight fetches.

## Interface
- ADDR_WIDTH, 16, instruction address width
- DATA_WIDTH, 16, instruction word width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- inst_addr  out  ADDR_WIDTH  sram0 address; driven directly from the pc register
- inst_re  out  1  read strobe; combinational, sram0 samples inst_addr when high
- inst_rdata  in  DATA_WIDTH  sram0 read data, valid in the cycle after the issuing inst_re
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address
- halt  in  1  level: stop issuing new reads
- out_valid  out  1  queue head valid toward decode
- out_ready  in  1  decode accepts head
- out_inst  out  DATA_WIDTH  head instruction word
- out_pc  out  ADDR_WIDTH  address of head instruction
- count  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- FSM states: BOOT, FETCH, HOLD. Reset → BOOT. BOOT → FETCH (halt=0) or HOLD (halt=1) at the first edge. FETCH → HOLD when halt=1. HOLD → FETCH when halt=0.
- Issue: inst_re = (state==FETCH) & !halt & !redirect_valid & (count + pending < DEPTH).
- On issue, pc ← pc+1 with modulo 2^ADDR_WIDTH wrap (16'hFFFF → 0). pending ← 1 and records the issued pc. Without an issue, pending ← 0.
- Response: in a cycle with pending=1 and no redirect, {pending_pc, inst_rdata} is pushed into the queue at the cycle end.
- Pop: occurs when out_valid & out_ready. Push and pop in the same cycle leave count unchanged. Push to a full queue cannot occur, because the issue gate prevents it.
- Redirect (any state):
  - pc ← redirect_pc.
  - Queue cleared; count ← 0.
  - pending ← 0, and the response arriving this cycle is discarded.
  - inst_re is forced 0 this cycle.
  - A handshake in the same cycle counts as consumed by decode; all other entries are dropped.
  - The FSM state is unchanged.
- Halt: the queue keeps draining to decode; only new issue stops. A response already pending when halt rises is still pushed.
- Reset mid-operation: all state clears immediately and asynchronously. In-flight SRAM data is ignored.

## Timing
- Reset values: inst_addr=0, inst_re=0, out_valid=0, out_inst=0, out_pc=0, count=0, pc=0, pending=0, state=BOOT.
- Fetch latency: issue in cycle T; data is captured at the end of T+1; out_valid is high from T+2.
- First fetch after reset release: address 0 is issued in the first cycle after BOOT.
- Redirect in cycle N: first issue of redirect_pc in N+1; out_valid for it in N+3.
- Throughput: one instruction per cycle with out_ready held high. The steady-state count + pending is 2, which is below DEPTH.
- Backpressure: with out_ready=0, issue stops once count + pending reaches DEPTH. No data is lost.
- out_inst and out_pc are registered queue-head outputs. They are stable while out_valid=1 and out_ready=0.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH constants
  - RESET_PC (0)
  - fetch FSM state enum (BOOT, FETCH, HOLD)
  - fetch entry struct {pc, inst}
- Sub-module fetch_fifo: a synchronous DEPTH-entry FIFO of fetch entries with push, pop, clear (clear has priority over push), count, and head outputs.

## Test plan
- Reset, then halt=0, out_ready=1, sram0 holds word k = 16'h7000+k → inst_addr 0,1,2,… every cycle. The first out_valid appears 2 cycles after the first issue, with out_pc=0 and out_inst=16'h7000. Thereafter one instruction per cycle in order.
- Backpressure: hold out_ready=0 → exactly DEPTH=4 entries (pc 0–3) are queued, inst_re drops, and count=4. Release out_ready → pc 0–3 drain in order, then issue resumes at pc 4.
- Redirect with redirect_pc=16'h0040 while pc 5 is in flight and 2 entries are queued → queue cleared and the pc-5 data dropped. The next out_valid carries out_pc=16'h0040 three cycles after the redirect.
- Redirect coincident with a head handshake on pc 3 → decode receives pc 3 exactly once. The next delivered instruction is at redirect_pc.
- Halt asserted for 5 cycles → no inst_re. The queue drains to count 0 and out_valid drops. Deasserting halt resumes fetch at the next sequential pc.
- Redirect to 16'hFFFE → out_pc sequence FFFE, FFFF, 0000, 0001.
